// File: rtl/wave_gen.sv
// Waveform sample generator: a prescaler-paced phase accumulator drives a waveform
// lookup, and each sample is presented on a valid/ready handshake to the downstream filter.
module wave_gen #(
    parameter int unsigned DIV_W = 32,
    parameter int unsigned PH_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [7:0]       cfg_step,
    input  logic [1:0]       cfg_wave,
    output logic [3:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [PH_W-1:0]  phase,
    output logic             wrap,
    output logic             overrun,
    output logic             cfg_reject
);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [3:0]       dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             overrun_q, overrun_d;
    logic             reject_q, reject_d;
    logic [DIV_W-1:0] cfg_div_q, cfg_div_d;
    logic [7:0]       cfg_step_q, cfg_step_d;
    logic [1:0]       cfg_wave_q, cfg_wave_d;

    logic [DIV_W-1:0] div_eff;
    logic             tick;
    logic [PH_W:0]    phase_sum;
    logic [3:0]       sample;

    // First quarter of the sine (indices 0..64), expressed as the index thresholds
    // where floor(8 + 7.5*sin) steps up by one.
    function automatic logic [3:0] sine_quarter(input logic [6:0] j);
        if (j < 7'd6)       return 4'd8;
        else if (j < 7'd11) return 4'd9;
        else if (j < 7'd17) return 4'd10;
        else if (j < 7'd23) return 4'd11;
        else if (j < 7'd30) return 4'd12;
        else if (j < 7'd38) return 4'd13;
        else if (j < 7'd50) return 4'd14;
        else                return 4'd15;
    endfunction

    // Full 256x4 table folded from the quarter wave; the negative half mirrors as 15-f,
    // except at index 128 where sin is exactly zero.
    function automatic logic [3:0] sine_rom(input logic [7:0] i);
        logic [6:0] j;
        logic [3:0] q;
        j = (i[6:0] <= 7'd64) ? i[6:0] : 7'(8'd128 - {1'b0, i[6:0]});
        q = sine_quarter(j);
        if (!i[7])                 return q;
        else if (i[6:0] == 7'd0)   return 4'd8;
        else                       return 4'd15 - q;
    endfunction

    assign div_eff   = (cfg_div_q == '0) ? DIV_W'(1) : cfg_div_q;
    assign tick      = (presc_q == div_eff - DIV_W'(1));
    assign phase_sum = {1'b0, phase_q} + (PH_W + 1)'(cfg_step_q);

    always_comb begin
        sample = 4'd8;
        case (cfg_wave_q)
            2'd0:    sample = sine_rom(phase_q[7:0]);
            2'd1:    sample = phase_q[7] ? 4'd15 : 4'd0;
            2'd2:    sample = phase_q[7:4];
            default: sample = 4'd8;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        phase_d    = phase_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        wrap_d     = 1'b0;
        overrun_d  = overrun_q;
        reject_d   = 1'b0;
        cfg_div_d  = cfg_div_q;
        cfg_step_d = cfg_step_q;
        cfg_wave_d = cfg_wave_q;

        if (cfg_load) begin
            if (state_q == StIdle) begin
                cfg_div_d  = cfg_div;
                cfg_step_d = cfg_step;
                cfg_wave_d = cfg_wave;
                overrun_d  = 1'b0;
            end else begin
                reject_d = 1'b1;
            end
        end

        if (!en) begin
            state_d = StIdle;
            presc_d = '0;
            valid_d = 1'b0;
        end else if (state_q == StIdle) begin
            state_d = StRun;
            presc_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + DIV_W'(1);
            if (valid_q && dout_ready) valid_d = 1'b0;
            if (tick) begin
                phase_d = phase_sum[PH_W-1:0];
                wrap_d  = phase_sum[PH_W];
                // An unaccepted sample is kept; the new one is dropped and flagged.
                if (valid_q && !dout_ready) begin
                    overrun_d = 1'b1;
                end else begin
                    dout_d  = sample;
                    valid_d = 1'b1;
                end
            end
            state_d = (valid_d && !dout_ready) ? StHold : StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            phase_q    <= '0;
            dout_q     <= 4'd0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            overrun_q  <= 1'b0;
            reject_q   <= 1'b0;
            cfg_div_q  <= DIV_W'(1);
            cfg_step_q <= 8'd1;
            cfg_wave_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            phase_q    <= phase_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
            overrun_q  <= overrun_d;
            reject_q   <= reject_d;
            cfg_div_q  <= cfg_div_d;
            cfg_step_q <= cfg_step_d;
            cfg_wave_q <= cfg_wave_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign phase      = phase_q;
    assign wrap       = wrap_q;
    assign overrun    = overrun_q;
    assign cfg_reject = reject_q;

endmodule
